// File: rtl/source_logic.sv
// Five-input Boolean function unit: y = TRUTH_TABLE[x], built as a sum of
// minterms over x[4:0], optionally captured in an async-reset output register.
module source_logic #(
    parameter logic [31:0] TRUTH_TABLE  = 32'hA08A28AC,
    parameter bit          REGISTER_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] x,
    output logic       y
);

    logic [31:0] minterm;
    logic        f_x;

    // One product term per table bit that is set; cleared bits contribute nothing.
    for (genvar k = 0; k < 32; k++) begin : g_minterm
        localparam logic [4:0] K = 5'(k);
        if (TRUTH_TABLE[k]) begin : g_on
            assign minterm[k] = &(~(x ^ K));
        end else begin : g_off
            assign minterm[k] = 1'b0;
        end
    end

    assign f_x = |minterm;

    if (REGISTER_OUT) begin : g_reg
        logic y_p0;

        // Stage 0: output register, cleared immediately by rst
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                y_p0 <= 1'b0;
            end else begin
                y_p0 <= f_x;
            end
        end

        assign y = y_p0;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst};
        assign y = f_x;
    end

endmodule

// File: tb/tb_source_logic.sv
// Bench for source_logic: scoreboard-checked registered instance against a
// primality model, plus directed reset checks and a combinational override.
module tb_source_logic;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] x   = 5'd3;
    logic       y;

    logic       clk_c = 1'b0;
    logic       rst_c = 1'b0;
    logic [4:0] x_c   = 5'd0;
    logic       y_c;

    int checks = 0;
    int errors = 0;
    bit track  = 1'b0;

    bit       exp_q[$];
    bit [4:0] xq[$];

    source_logic dut (
        .clk(clk),
        .rst(rst),
        .x  (x),
        .y  (y)
    );

    source_logic #(
        .TRUTH_TABLE (32'h0000_0001),
        .REGISTER_OUT(1'b0)
    ) dut_c (
        .clk(clk_c),
        .rst(rst_c),
        .x  (x_c),
        .y  (y_c)
    );

    always #5 clk = ~clk;

    function automatic bit is_prime(int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d < n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: y=%b expected %b", nm, act, exp);
        end
    endtask

    // Expected response for the value captured at each rising edge.
    always @(posedge clk) begin
        if (track) begin
            exp_q.push_back(rst ? 1'b0 : is_prime(int'(x)));
            xq.push_back(x);
        end
    end

    // Monitor: compare half a cycle after each captured edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check($sformatf("sb x=%0d", xq.pop_front()), y, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int list[9] = '{0, 1, 30, 31, 9, 15, 21, 25, 27};
        int n;

        // Reset held with x = 3
        #1;
        check("reset_immediate", y, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", y, 1'b0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check("reset_release", y, 1'b1);

        track = 1'b1;

        for (int v = 0; v < 32; v++) begin
            x = 5'(v);
            repeat (2) @(posedge clk);
            #1;
        end

        for (int i = 0; i < 9; i++) begin
            x = 5'(list[i]);
            @(posedge clk);
            #1;
        end

        // Random values, some with an extra change between edges
        repeat (150) begin
            x = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                #2 x = 5'($urandom_range(0, 31));
            end
            @(posedge clk);
            #1;
        end

        track = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        // Asynchronous reset pulse between edges
        x = 5'd23;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (y !== 1'b1 && n < 5);
        check("async_pre", y, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_assert", y, 1'b0);
        #2 rst = 1'b0;
        #1 check("async_still_low", y, 1'b0);
        @(posedge clk);
        #1 check("async_recover", y, 1'b1);

        // Combinational override, no clock involved
        for (int v = 0; v < 32; v++) begin
            x_c = 5'(v);
            #1 check($sformatf("comb x=%0d", v), y_c, (v == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/source_logic.md
Name:
source_logic

Overview:
- 5-input, 1-output Boolean function block: y is asserted when the unsigned 5-bit input x is a prime number (default function).
- Function is defined by a 32-entry truth-table parameter indexed by x; result is captured in an output register.
- Used as a lab-level combinational function unit, sampled by one system clock for glitch-free timing diagrams.

Parameters:
- TRUTH_TABLE, 32'hA08A28AC, bit k is the value of y for x == k. The default sets bits 2,3,5,7,11,13,17,19,23,29,31 (the primes).
- REGISTER_OUT, 1, 1 = y is registered (1-cycle latency); 0 = y is a purely combinational decode of x, with clk/rst unused.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- x    input  5  function input, unsigned 0..31, x[4] is MSB
- y    output 1  function output

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). Polarity and synchronicity are fixed.
- Decode: f(x) = TRUTH_TABLE[x]. It must be implemented as a sum-of-products over x[4:0] (minterm decode or equivalent reduced logic), not a behavioural lookup.
- Default minterms for y = 1: x = 2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31. All other x give y = 0, including 0, 1, 9, 15, 21, 25 and 27.
- REGISTER_OUT = 1:
  - On posedge clk with rst low: y <= f(x).
  - Latency is 1 cycle from x stable before a rising edge to y valid after that edge.
  - y holds between edges, so input changes between edges produce no output glitches.
- Reset:
  - While rst is high, y = 0 immediately (asynchronous), regardless of clk or x.
  - On rst deassertion, the first rising edge loads f(x).
  - Reset asserted mid-stream clears y at once. No other state exists.
- REGISTER_OUT = 0: y = f(x) combinationally. Reset has no effect.
- X/Z on any x bit: y is don't-care (no defined requirement). The verification bench must only drive known values.
- No handshake, no enable. x is sampled every cycle.
- Width rules: x is treated as unsigned. Indices 0..31 cover the full table, so no out-of-range case exists.

Test Plan:
- Reset: rst=1 with x=5'b00011 -> y=0 immediately and on every edge while rst=1. Release rst -> y=1 after the first rising edge.
- Exhaustive sweep: x = 0..31 in ascending order, each held ≥2 clocks, with REGISTER_OUT=1 -> y=1 exactly for x ∈ {2,3,5,7,11,13,17,19,23,29,31}, one cycle after each change. Otherwise y=0.
- Boundaries: x=5'b00000 -> 0; 5'b00001 -> 0; 5'b11110 -> 0; 5'b11111 -> 1.
- Odd non-primes: x = 9, 15, 21, 25, 27 -> y=0.
- Async reset mid-run: hold x=5'b10111 (23) until y=1, then pulse rst high between clock edges -> y falls to 0 without waiting for an edge, and returns to 1 on the first edge after release.
- Parameter override: TRUTH_TABLE=32'h0000_0001, REGISTER_OUT=0 -> y=1 only for x=0, with combinational response and no clock needed.
